// File: rtl/mlp_layer_sequencer_if.sv
// Parameter-memory read port and MLP core host-load/control bus seen by the layer sequencer.
// master = sequencer side, slave = core + parameter-memory side.
interface mlp_layer_sequencer_if #(
  parameter int PMEM_AW = 16
);
  logic               pm_rd_en;
  logic [PMEM_AW-1:0] pm_addr;
  logic [7:0]         pm_rd_data;

  logic               core_start;
  logic               core_done;
  logic [15:0]        core_num_inputs;
  logic [15:0]        core_num_outputs;
  logic [15:0]        core_input_addr;
  logic [15:0]        core_weight_addr;
  logic [15:0]        core_bias_addr;
  logic [7:0]         core_input_data;
  logic [7:0]         core_weight_data;
  logic [7:0]         core_bias_data;
  logic               core_input_we;
  logic               core_weight_we;
  logic               core_bias_we;
  logic [7:0]         core_output_data;
  logic               core_output_valid;

  modport master (
    output pm_rd_en, pm_addr,
    input  pm_rd_data,
    output core_start, core_num_inputs, core_num_outputs,
    output core_input_addr, core_weight_addr, core_bias_addr,
    output core_input_data, core_weight_data, core_bias_data,
    output core_input_we, core_weight_we, core_bias_we,
    input  core_done, core_output_data, core_output_valid
  );

  modport slave (
    input  pm_rd_en, pm_addr,
    output pm_rd_data,
    input  core_start, core_num_inputs, core_num_outputs,
    input  core_input_addr, core_weight_addr, core_bias_addr,
    input  core_input_data, core_weight_data, core_bias_data,
    input  core_input_we, core_weight_we, core_bias_we,
    output core_done, core_output_data, core_output_valid
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Multi-layer scheduler for the fully-connected MLP core: loads each layer's inputs,
// weights and biases, runs the core and ping-pongs activations between buffers A and B.
module mlp_layer_sequencer #(
  parameter int MAX_LAYERS = 8,
  parameter int ACT_DEPTH  = 256,
  parameter int PMEM_AW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_layer,
  input  logic [15:0]        cfg_num_in,
  input  logic [15:0]        cfg_num_out,
  input  logic [PMEM_AW-1:0] cfg_wbase,
  input  logic [3:0]         cfg_num_layers,
  input  logic               in_we,
  input  logic [7:0]         in_addr,
  input  logic [7:0]         in_data,
  input  logic               run_start,
  output logic               run_busy,
  output logic               run_done,
  output logic               run_error,
  input  logic [7:0]         res_addr,
  output logic [7:0]         res_data,
  mlp_layer_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_LOAD_IN, S_LOAD_W, S_LOAD_B, S_START,
    S_WAIT, S_RELEASE, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t state;

  logic [15:0]        tbl_n  [MAX_LAYERS];
  logic [15:0]        tbl_m  [MAX_LAYERS];
  logic [PMEM_AW-1:0] tbl_wb [MAX_LAYERS];
  logic [7:0]         buf_a  [ACT_DEPTH];
  logic [7:0]         buf_b  [ACT_DEPTH];

  logic [2:0]         layer;
  logic [3:0]         n_layers;
  logic               src_b;
  logic               final_b;
  logic [15:0]        cur_n;
  logic [15:0]        cur_m;
  logic [PMEM_AW-1:0] cur_wb;
  logic [15:0]        nm;
  logic [15:0]        cnt;
  logic [8:0]         out_cnt;
  logic [8:0]         out_cnt_nx;

  logic               inp_vld_p1;
  logic [15:0]        inp_addr_p1;
  logic [7:0]         inp_data_p1;
  logic               wt_vld_p1;
  logic [15:0]        wt_addr_p1;
  logic               bias_vld_p1;
  logic [15:0]        bias_addr_p1;
  logic               pm_rd_en_r;
  logic [PMEM_AW-1:0] pm_addr_r;
  logic               core_start_r;

  logic [15:0]        d_n;
  logic [15:0]        d_m;
  logic [31:0]        d_nm;
  logic               chk_bad;
  logic               host_ok;
  logic               cap_we;

  assign host_ok = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign run_busy = (state != S_IDLE);
  assign cap_we = (state == S_WAIT) && bus.core_output_valid && (out_cnt < 9'(ACT_DEPTH));
  assign out_cnt_nx = (bus.core_output_valid && (out_cnt != 9'h1ff)) ? out_cnt + 9'd1 : out_cnt;

  // Descriptor of the layer about to start, and every reason to refuse it
  always_comb begin
    d_n     = tbl_n[layer];
    d_m     = tbl_m[layer];
    d_nm    = 32'(d_n) * 32'(d_m);
    chk_bad = (n_layers == 4'd0) || (int'(n_layers) > MAX_LAYERS) ||
              (d_n == 16'd0) || (d_m == 16'd0) ||
              (int'(d_n) > ACT_DEPTH) || (int'(d_m) > ACT_DEPTH) ||
              (d_nm > 32'd16384) ||
              ((layer != 3'd0) && (d_n != cur_m));
  end

  always_ff @(posedge clk) begin
    if (host_ok && cfg_we) begin
      tbl_n[cfg_layer]  <= cfg_num_in;
      tbl_m[cfg_layer]  <= cfg_num_out;
      tbl_wb[cfg_layer] <= cfg_wbase;
    end
  end

  // Host writes only land in A; core results go to whichever buffer is not the source
  always_ff @(posedge clk) begin
    if (host_ok && in_we)
      buf_a[in_addr] <= in_data;
    if (cap_we) begin
      if (src_b) buf_a[out_cnt[7:0]] <= bus.core_output_data;
      else       buf_b[out_cnt[7:0]] <= bus.core_output_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      run_done     <= 1'b0;
      run_error    <= 1'b0;
      res_data     <= 8'd0;
      layer        <= 3'd0;
      n_layers     <= 4'd0;
      src_b        <= 1'b0;
      final_b      <= 1'b0;
      cur_n        <= 16'd0;
      cur_m        <= 16'd0;
      cur_wb       <= '0;
      nm           <= 16'd0;
      cnt          <= 16'd0;
      out_cnt      <= 9'd0;
      inp_vld_p1   <= 1'b0;
      inp_addr_p1  <= 16'd0;
      inp_data_p1  <= 8'd0;
      wt_vld_p1    <= 1'b0;
      wt_addr_p1   <= 16'd0;
      bias_vld_p1  <= 1'b0;
      bias_addr_p1 <= 16'd0;
      pm_rd_en_r   <= 1'b0;
      pm_addr_r    <= '0;
      core_start_r <= 1'b0;
    end else begin
      res_data    <= final_b ? buf_b[res_addr] : buf_a[res_addr];
      run_done    <= 1'b0;
      inp_vld_p1  <= 1'b0;
      wt_vld_p1   <= 1'b0;
      bias_vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run_start) begin
            state     <= S_CHECK;
            run_error <= 1'b0;
            layer     <= 3'd0;
            src_b     <= 1'b0;
            n_layers  <= cfg_num_layers;
          end
        end
        S_CHECK: begin
          if (chk_bad) begin
            state     <= S_ERR;
            run_error <= 1'b1;
          end else begin
            cur_n  <= d_n;
            cur_m  <= d_m;
            cur_wb <= tbl_wb[layer];
            nm     <= d_nm[15:0];
            cnt    <= 16'd0;
            state  <= S_LOAD_IN;
          end
        end
        // ---- p0: read issue (buffer / param memory), p1: core load strobe ----
        S_LOAD_IN: begin
          if (cnt < cur_n) begin
            inp_vld_p1  <= 1'b1;
            inp_addr_p1 <= cnt;
            inp_data_p1 <= src_b ? buf_b[cnt[7:0]] : buf_a[cnt[7:0]];
            cnt         <= cnt + 16'd1;
          end else begin
            state      <= S_LOAD_W;
            pm_rd_en_r <= 1'b1;
            pm_addr_r  <= cur_wb;
            cnt        <= 16'd0;
          end
        end
        S_LOAD_W: begin
          if (pm_rd_en_r) begin
            wt_vld_p1  <= 1'b1;
            wt_addr_p1 <= cnt;
            if (cnt + 16'd1 < nm) begin
              cnt       <= cnt + 16'd1;
              pm_addr_r <= pm_addr_r + PMEM_AW'(1);
            end else begin
              pm_rd_en_r <= 1'b0;
            end
          end else begin
            // Biases sit directly after the weight block
            state      <= S_LOAD_B;
            pm_rd_en_r <= 1'b1;
            pm_addr_r  <= pm_addr_r + PMEM_AW'(1);
            cnt        <= 16'd0;
          end
        end
        S_LOAD_B: begin
          if (pm_rd_en_r) begin
            bias_vld_p1  <= 1'b1;
            bias_addr_p1 <= cnt;
            if (cnt + 16'd1 < cur_m) begin
              cnt       <= cnt + 16'd1;
              pm_addr_r <= pm_addr_r + PMEM_AW'(1);
            end else begin
              pm_rd_en_r <= 1'b0;
            end
          end else begin
            state        <= S_START;
            core_start_r <= 1'b1;
            out_cnt      <= 9'd0;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          out_cnt <= out_cnt_nx;
          if (bus.core_done) begin
            core_start_r <= 1'b0;
            if ({7'd0, out_cnt_nx} != cur_m) begin
              state     <= S_ERR;
              run_error <= 1'b1;
            end else begin
              state <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (!bus.core_done) state <= S_NEXT;
        end
        S_NEXT: begin
          src_b <= ~src_b;
          if ({1'b0, layer} + 4'd1 < n_layers) begin
            layer <= layer + 3'd1;
            state <= S_CHECK;
          end else begin
            final_b  <= ~src_b;
            run_done <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERR: begin
          core_start_r <= 1'b0;
          if (!bus.core_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pm_rd_en         = pm_rd_en_r;
  assign bus.pm_addr          = pm_addr_r;
  assign bus.core_start       = core_start_r;
  assign bus.core_num_inputs  = cur_n;
  assign bus.core_num_outputs = cur_m;
  assign bus.core_input_we    = inp_vld_p1;
  assign bus.core_input_addr  = inp_addr_p1;
  assign bus.core_input_data  = inp_data_p1;
  assign bus.core_weight_we   = wt_vld_p1;
  assign bus.core_weight_addr = wt_addr_p1;
  assign bus.core_weight_data = wt_vld_p1 ? bus.pm_rd_data : 8'd0;
  assign bus.core_bias_we     = bias_vld_p1;
  assign bus.core_bias_addr   = bias_addr_p1;
  assign bus.core_bias_data   = bias_vld_p1 ? bus.pm_rd_data : 8'd0;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench for mlp_layer_sequencer: behavioural core + parameter memory,
// randomized multi-layer runs compared against a plain-arithmetic MLP reference.
module tb_mlp_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_layer = '0;
  logic [15:0] cfg_num_in = '0;
  logic [15:0] cfg_num_out = '0;
  logic [15:0] cfg_wbase = '0;
  logic [3:0]  cfg_num_layers = '0;
  logic        in_we = 1'b0;
  logic [7:0]  in_addr = '0;
  logic [7:0]  in_data = '0;
  logic        run_start = 1'b0;
  logic        run_busy, run_done, run_error;
  logic [7:0]  res_addr = '0;
  logic [7:0]  res_data;

  always #5 clk = ~clk;

  mlp_layer_sequencer_if #(.PMEM_AW(16)) bus ();

  mlp_layer_sequencer #(.MAX_LAYERS(8), .ACT_DEPTH(256), .PMEM_AW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_num_in(cfg_num_in),
    .cfg_num_out(cfg_num_out), .cfg_wbase(cfg_wbase), .cfg_num_layers(cfg_num_layers),
    .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .run_start(run_start), .run_busy(run_busy), .run_done(run_done), .run_error(run_error),
    .res_addr(res_addr), .res_data(res_data),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int relu8(input int v);
    if (v < 0) return 0;
    if (v > 127) return 127;
    return v;
  endfunction

  logic [7:0] pmem [65536];
  always @(posedge clk) if (bus.pm_rd_en) bus.pm_rd_data <= pmem[bus.pm_addr];

  // Monitor: what the core has been loaded with, plus run statistics
  logic signed [7:0] cin [256];
  logic signed [7:0] cw  [16384];
  logic signed [7:0] cb  [256];
  int n_starts = 0, n_done = 0, n_overlap = 0, pm_min = 0, pm_max = 0, pm_reads = 0;
  logic start_q = 1'b0, busy_q = 1'b0;

  always @(negedge clk) begin
    if (run_busy && !busy_q) begin
      pm_min = 1 << 30; pm_max = -1; pm_reads = 0;
    end
    busy_q = run_busy;
    if (bus.core_input_we)  cin[bus.core_input_addr[7:0]]  = bus.core_input_data;
    if (bus.core_weight_we) cw[bus.core_weight_addr[13:0]] = bus.core_weight_data;
    if (bus.core_bias_we)   cb[bus.core_bias_addr[7:0]]    = bus.core_bias_data;
    if (int'(bus.core_input_we) + int'(bus.core_weight_we) + int'(bus.core_bias_we) > 1)
      n_overlap++;
    if (run_done) n_done++;
    if (bus.core_start && !start_q) n_starts++;
    start_q = bus.core_start;
    if (bus.pm_rd_en) begin
      pm_reads++;
      if (int'(bus.pm_addr) < pm_min) pm_min = int'(bus.pm_addr);
      if (int'(bus.pm_addr) > pm_max) pm_max = int'(bus.pm_addr);
    end
  end

  // Behavioural core: computes from loaded contents, streams results, then handshakes done
  bit short_mode = 1'b0;
  bit coincide   = 1'b0;
  initial begin : core_model
    int n, m, cnt_o, acc;
    int outv [256];
    bus.core_done = 1'b0;
    bus.core_output_valid = 1'b0;
    bus.core_output_data = 8'd0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.core_start && !bus.core_done) begin
        n = int'(bus.core_num_inputs);
        m = int'(bus.core_num_outputs);
        for (int j = 0; j < m; j++) begin
          acc = int'(cb[j]);
          for (int i = 0; i < n; i++) acc += int'(cin[i]) * int'(cw[j*n+i]);
          outv[j] = relu8(acc);
        end
        cnt_o = short_mode ? m - 1 : m;
        @(negedge clk);
        @(negedge clk);
        for (int j = 0; j < cnt_o; j++) begin
          bus.core_output_valid = 1'b1;
          bus.core_output_data = 8'(outv[j]);
          if (coincide && j == cnt_o - 1) bus.core_done = 1'b1;
          @(negedge clk);
        end
        bus.core_output_valid = 1'b0;
        bus.core_done = 1'b1;
        for (int k = 0; k < 200 && bus.core_start; k++) @(negedge clk);
        bus.core_done = 1'b0;
      end
    end
  end

  int t_nl;
  int t_n [8], t_m [8], t_wb [8];
  logic [7:0] hin [256];
  int exp_res [256];
  int exp_len;

  task automatic ref_model();
    int act [256];
    int nxt [256];
    int acc, n, m, wb;
    for (int i = 0; i < 256; i++) act[i] = int'($signed(hin[i]));
    m = 0;
    for (int l = 0; l < t_nl; l++) begin
      n = t_n[l]; m = t_m[l]; wb = t_wb[l];
      for (int j = 0; j < m; j++) begin
        acc = int'($signed(pmem[wb + n*m + j]));
        for (int i = 0; i < n; i++) acc += act[i] * int'($signed(pmem[wb + j*n + i]));
        nxt[j] = relu8(acc);
      end
      for (int j = 0; j < m; j++) act[j] = nxt[j];
    end
    exp_len = m;
    for (int j = 0; j < m; j++) exp_res[j] = act[j];
  endtask

  task automatic program_all();
    for (int l = 0; l < t_nl && l < 8; l++) begin
      cfg_we = 1'b1; cfg_layer = 3'(l);
      cfg_num_in = 16'(t_n[l]); cfg_num_out = 16'(t_m[l]); cfg_wbase = 16'(t_wb[l]);
      @(negedge clk);
      cfg_we = 1'b0;
    end
    for (int i = 0; i < t_n[0] && i < 256; i++) begin
      in_we = 1'b1; in_addr = 8'(i); in_data = hin[i];
      @(negedge clk);
      in_we = 1'b0;
    end
    cfg_num_layers = 4'(t_nl);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40000 && run_busy; k++) @(negedge clk);
    check({tag, "_idle"}, run_busy, 1'b0);
  endtask

  task automatic do_run(input string tag);
    run_start = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
    wait_idle(tag);
  endtask

  task automatic check_results(input string tag);
    ref_model();
    for (int j = 0; j < exp_len; j++) begin
      res_addr = 8'(j);
      @(negedge clk);
      @(negedge clk);
      check($sformatf("%s_res%0d", tag, j), res_data, exp_res[j]);
    end
  endtask

  task automatic gen_random(input int nl);
    t_nl = nl;
    t_n[0] = $urandom_range(1, 12);
    for (int l = 0; l < nl; l++) begin
      t_m[l] = $urandom_range(1, 12);
      if (l > 0) t_n[l] = t_m[l-1];
      t_wb[l] = l * 2048 + $urandom_range(0, 100);
    end
    for (int i = 0; i < 256; i++) hin[i] = 8'($urandom);
  endtask

  task automatic expect_error(input string tag);
    int d0;
    d0 = n_done;
    program_all();
    do_run(tag);
    check({tag, "_err"}, run_error, 1'b1);
    check({tag, "_nodone"}, n_done - d0, 0);
  endtask

  initial begin : stim
    int d0, s0;
    logic [31:0] any_out;
    bit seen;
    for (int i = 0; i < 65536; i++) pmem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_busy", run_busy, 1'b0);
    check("rst_done", run_done, 1'b0);
    check("rst_error", run_error, 1'b0);
    check("rst_core_start", bus.core_start, 1'b0);
    check("rst_pm_rd_en", bus.pm_rd_en, 1'b0);
    check("rst_res_data", res_data, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed single layer 4->2
    t_nl = 1; t_n[0] = 4; t_m[0] = 2; t_wb[0] = 100;
    for (int i = 0; i < 4; i++) begin pmem[100+i] = 8'd1; pmem[104+i] = 8'hFF; end
    pmem[108] = 8'd0; pmem[109] = 8'd5;
    for (int i = 0; i < 4; i++) hin[i] = 8'(i + 1);
    program_all();
    d0 = n_done;
    do_run("t1");
    res_addr = 8'd0; @(negedge clk); @(negedge clk);
    check("t1_res0", res_data, 8'd10);
    res_addr = 8'd1; @(negedge clk); @(negedge clk);
    check("t1_res1", res_data, 8'd0);
    check("t1_done_once", n_done - d0, 1);
    check("t1_pm_min", pm_min, 100);
    check("t1_pm_max", pm_max, 109);
    check("t1_pm_reads", pm_reads, 10);
    check("t1_error", run_error, 1'b0);

    // Two layers: 4->2 then 2->1
    t_nl = 2; t_n[1] = 2; t_m[1] = 1; t_wb[1] = 200;
    pmem[200] = 8'd2; pmem[201] = 8'd3; pmem[202] = 8'hFF;
    program_all();
    s0 = n_starts;
    do_run("t2");
    res_addr = 8'd0; @(negedge clk); @(negedge clk);
    check("t2_res0", res_data, 8'd19);
    check("t2_l1_in0", 32'(cin[0]), 32'(8'sd10));
    check("t2_l1_in1", 32'(cin[1]), 32'd0);
    check("t2_starts", n_starts - s0, 2);

    // Layer chaining mismatch: layer 1 wants 3 inputs after 2 outputs
    t_n[1] = 3;
    s0 = n_starts;
    expect_error("t3");
    check("t3_starts", n_starts - s0, 1);

    // Core delivers one output short
    t_nl = 1; short_mode = 1'b1;
    expect_error("t4");
    check("t4_core_start", bus.core_start, 1'b0);
    short_mode = 1'b0;

    // Reset while weights are streaming
    program_all();
    run_start = 1'b1; @(negedge clk); run_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (bus.pm_rd_en && bus.pm_addr >= 16'd103) seen = 1'b1;
      else @(negedge clk);
    end
    check("t5_in_load_w", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    any_out = 32'(|{run_busy, run_done, run_error, res_data, bus.pm_rd_en, bus.pm_addr,
                    bus.core_start, bus.core_num_inputs, bus.core_num_outputs,
                    bus.core_input_addr, bus.core_weight_addr, bus.core_bias_addr,
                    bus.core_input_data, bus.core_weight_data, bus.core_bias_data,
                    bus.core_input_we, bus.core_weight_we, bus.core_bias_we});
    check("t5_outputs_zero", any_out, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gen_random(2);
    program_all();
    d0 = n_done;
    do_run("t5_after");
    check("t5_done_once", n_done - d0, 1);
    check_results("t5_after");

    // run_start and in_we during WAIT are ignored
    gen_random(1);
    program_all();
    d0 = n_done;
    run_start = 1'b1; @(negedge clk); run_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      if (bus.core_start) seen = 1'b1;
      else @(negedge clk);
    end
    check("t6_core_start", seen, 1'b1);
    @(negedge clk);
    run_start = 1'b1; in_we = 1'b1; in_addr = 8'd0; in_data = ~hin[0];
    @(negedge clk);
    run_start = 1'b0; in_we = 1'b0;
    wait_idle("t6");
    check("t6_done_once", n_done - d0, 1);
    check_results("t6");
    do_run("t6_rerun");
    check_results("t6_rerun");

    // Largest legal layer width, then a narrowing layer
    t_nl = 2; t_n[0] = 256; t_m[0] = 3; t_wb[0] = 10000;
    t_n[1] = 3; t_m[1] = 2; t_wb[1] = 12000;
    for (int i = 0; i < 256; i++) hin[i] = 8'($urandom);
    program_all();
    coincide = 1'b1;
    do_run("t7");
    check("t7_error", run_error, 1'b0);
    check_results("t7");
    coincide = 1'b0;

    // Descriptor limits
    t_nl = 1; t_n[0] = 4; t_m[0] = 2; t_wb[0] = 100;
    t_nl = 0; expect_error("t8_nl0");
    t_nl = 9; for (int l = 0; l < 8; l++) begin t_n[l] = 2; t_m[l] = 2; t_wb[l] = 300; end
    expect_error("t8_nl9");
    t_nl = 1; t_n[0] = 257; t_m[0] = 1; expect_error("t8_n257");
    t_n[0] = 200; t_m[0] = 100; expect_error("t8_nm");
    t_n[0] = 0; t_m[0] = 2; expect_error("t8_n0");

    // Randomized multi-layer runs
    for (int r = 0; r < 8; r++) begin
      gen_random($urandom_range(1, 4));
      coincide = bit'($urandom_range(0, 1));
      program_all();
      d0 = n_done;
      do_run($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_error", r), run_error, 1'b0);
      check($sformatf("rnd%0d_done", r), n_done - d0, 1);
      check_results($sformatf("rnd%0d", r));
    end

    check("no_strobe_overlap", n_overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
